// File: rtl/apb_cmd_master_if.sv
// Command/response stream plus APB3 bus bundle for apb_cmd_master.
// master modport is the requester's view; slave is the view of whatever drives the stream and completer.
interface apb_cmd_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic              cmd_write;
    logic [DATA_W-1:0] cmd_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;
    logic              busy;

    logic              PSEL;
    logic              PENABLE;
    logic [ADDR_W-1:0] PADDR;
    logic              PWRITE;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        input  cmd_valid, cmd_addr, cmd_write, cmd_wdata, rsp_ready,
        input  PRDATA, PREADY, PSLVERR,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy,
        output PSEL, PENABLE, PADDR, PWRITE, PWDATA
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_write, cmd_wdata, rsp_ready,
        output PRDATA, PREADY, PSLVERR,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy,
        input  PSEL, PENABLE, PADDR, PWRITE, PWDATA
    );
endinterface

// File: rtl/apb_cmd_master.sv
// APB3 requester: turns one valid/ready command into a SETUP/ACCESS transfer and
// returns read data / error on a valid/ready response, with a bounded wait-state timeout.
//   state  | meaning
//   IDLE   | bus idle, command accepted here only
//   SETUP  | PSEL=1, PENABLE=0, one cycle
//   ACCESS | PSEL=1, PENABLE=1, waiting for PREADY or timeout
//   RESP   | response held until rsp_ready
module apb_cmd_master #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TO_W           = 8
) (
    input logic                  PCLK,
    input logic                  PRESETn,
    apb_cmd_master_if.master     bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS, ST_RESP} state_t;

    localparam bit             TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT_CYCLES == 0) ? '0 : TO_W'(TIMEOUT_CYCLES - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_paddr;
    logic              r_pwrite;
    logic [DATA_W-1:0] r_pwdata;
    logic [TO_W-1:0]   r_cnt;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;
    logic              r_timeout;
    logic              w_accept;
    logic              w_complete;
    logic              w_abort;
    logic              w_expired;

    assign w_expired = TO_EN && (r_cnt == TO_LAST);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Bus strobes decode from r_state alone, so reset drops PSEL without waiting for a clock.
    always_comb begin
        w_state_nxt   = r_state;
        w_accept      = 1'b0;
        w_complete    = 1'b0;
        w_abort       = 1'b0;
        bus.cmd_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.busy      = 1'b1;
        bus.PSEL      = 1'b0;
        bus.PENABLE   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                bus.cmd_ready = 1'b1;
                bus.busy      = 1'b0;
                if (bus.cmd_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                bus.PSEL    = 1'b1;
                w_state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                bus.PSEL    = 1'b1;
                bus.PENABLE = 1'b1;
                if (bus.PREADY) begin
                    w_complete  = 1'b1;
                    w_state_nxt = ST_RESP;
                end else if (w_expired) begin
                    w_abort     = 1'b1;
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_paddr   <= '0;
            r_pwrite  <= 1'b0;
            r_pwdata  <= '0;
            r_cnt     <= '0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            if (w_accept) begin
                r_paddr  <= bus.cmd_addr;
                r_pwrite <= bus.cmd_write;
                r_pwdata <= bus.cmd_wdata;
            end
            if (r_state == ST_SETUP)
                r_cnt <= '0;
            else if (r_state == ST_ACCESS && !bus.PREADY)
                r_cnt <= r_cnt + TO_W'(1);
            if (w_complete) begin
                r_rdata   <= r_pwrite ? '0 : bus.PRDATA;
                r_err     <= bus.PSLVERR;
                r_timeout <= 1'b0;
            end else if (w_abort) begin
                r_rdata   <= '0;
                r_err     <= 1'b1;
                r_timeout <= 1'b1;
            end
        end
    end

    assign bus.PADDR       = r_paddr;
    assign bus.PWRITE      = r_pwrite;
    assign bus.PWDATA      = r_pwdata;
    assign bus.rsp_rdata   = r_rdata;
    assign bus.rsp_err     = r_err;
    assign bus.rsp_timeout = r_timeout;
endmodule
